// File: rtl/wb_slave_sram.sv
// Wishbone B4 slave backed by a word-addressed memory: classic cycles, registered-feedback
// incrementing bursts (linear / wrap-4/8/16), programmable wait states, ERR on out-of-range.
module wb_slave_sram #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int MEM_WORDS     = 1024
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [WB_ADDR_WIDTH-1:0]   ADR,
  input  logic [WB_DATA_WIDTH-1:0]   DAT_W,
  output logic [WB_DATA_WIDTH-1:0]   DAT_R,
  input  logic                       CYC,
  input  logic                       STB,
  input  logic                       WE,
  input  logic [WB_DATA_WIDTH/8-1:0] SEL,
  input  logic [2:0]                 CTI,
  input  logic [1:0]                 BTE,
  output logic                       ACK,
  output logic                       ERR,
  input  logic [3:0]                 wait_cycles
);

  // state  | meaning
  // S_IDLE | no cycle in progress; accept CYC&STB
  // S_WAIT | counting wait states before the first beat
  // S_RESP | ACK or ERR high this cycle
  // S_HOLD | master paused a burst (STB low, CYC high)

  localparam int NB  = WB_DATA_WIDTH / 8;
  localparam int OFF = $clog2(NB);
  localparam int IW  = WB_ADDR_WIDTH - OFF;
  localparam int MW  = $clog2(MEM_WORDS);

  localparam logic [2:0] CTI_INCR = 3'b010;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

  state_t                     state_q, state_d;
  logic [IW-1:0]              addr_q, addr_d;
  logic                       we_q, we_d;
  logic [NB-1:0]              sel_q, sel_d;
  logic [2:0]                 cti_q, cti_d;
  logic [1:0]                 bte_q, bte_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic                       ack_q, ack_d;
  logic                       err_q, err_d;
  logic [WB_DATA_WIDTH-1:0]   dat_q, dat_d;

  logic                       beat;
  logic [IW-1:0]              beat_addr;
  logic                       beat_we;
  logic [NB-1:0]              beat_sel;
  logic                       beat_oor;
  logic [IW-1:0]              adr_idx;
  logic [IW-1:0]              next_idx;
  logic [IW-1:0]              wrap_mask;

  logic [WB_DATA_WIDTH-1:0]   mem [MEM_WORDS];

  assign adr_idx = ADR[WB_ADDR_WIDTH-1:OFF];

  generate
    if (OFF > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^ADR[OFF-1:0];
    end
  endgenerate

  // Wrap bursts advance only the low index bits; linear uses an all-ones mask.
  always_comb begin
    case (bte_q)
      2'b01:   wrap_mask = IW'(3);
      2'b10:   wrap_mask = IW'(7);
      2'b11:   wrap_mask = IW'(15);
      default: wrap_mask = '1;
    endcase
    next_idx = (addr_q & ~wrap_mask) | ((addr_q + IW'(1)) & wrap_mask);
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    sel_d     = sel_q;
    cti_d     = cti_q;
    bte_d     = bte_q;
    cnt_d     = cnt_q;
    beat      = 1'b0;
    beat_addr = addr_q;
    beat_we   = we_q;
    beat_sel  = sel_q;
    case (state_q)
      S_IDLE: begin
        if (CYC && STB) begin
          addr_d = adr_idx;
          we_d   = WE;
          sel_d  = SEL;
          cti_d  = CTI;
          bte_d  = BTE;
          cnt_d  = wait_cycles;
          if (wait_cycles == 4'd0) begin
            beat      = 1'b1;
            beat_addr = adr_idx;
            beat_we   = WE;
            beat_sel  = SEL;
            state_d   = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!CYC) begin
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            cnt_d   = 4'd0;
            beat    = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      default: begin
        // S_RESP and S_HOLD; a hold is only ever entered with an incrementing CTI latched
        if (!CYC || cti_q != CTI_INCR) begin
          state_d = S_IDLE;
        end else if (STB) begin
          beat      = 1'b1;
          beat_addr = next_idx;
          beat_we   = WE;
          beat_sel  = SEL;
          addr_d    = next_idx;
          we_d      = WE;
          sel_d     = SEL;
          cti_d     = CTI;
          state_d   = S_RESP;
        end else begin
          state_d = S_HOLD;
        end
      end
    endcase
  end

  assign beat_oor = (beat_addr >= IW'(MEM_WORDS));

  always_comb begin
    ack_d = beat && !beat_oor;
    err_d = beat && beat_oor;
    dat_d = '0;
    if (beat && !beat_oor && !beat_we) dat_d = mem[beat_addr[MW-1:0]];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      cti_q   <= '0;
      bte_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      cti_q   <= cti_d;
      bte_q   <= bte_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // Memory survives reset; rstn only blocks a commit while reset is held.
  always_ff @(posedge clk) begin
    if (rstn && beat && beat_we && !beat_oor) begin
      for (int b = 0; b < NB; b++) begin
        if (beat_sel[b]) mem[beat_addr[MW-1:0]][8*b +: 8] <= DAT_W[8*b +: 8];
      end
    end
  end

  assign ACK   = ack_q;
  assign ERR   = err_q;
  assign DAT_R = dat_q;

endmodule

// File: tb/tb_wb_slave_sram.sv
// Directed bench for wb_slave_sram: classic, byte lanes, wait states, wrap/linear bursts,
// master hold, out-of-range ERR and reset in the middle of a write burst.
module tb_wb_slave_sram;

  logic        clk;
  logic        rstn;
  logic [31:0] ADR;
  logic [31:0] DAT_W;
  logic [31:0] DAT_R;
  logic        CYC;
  logic        STB;
  logic        WE;
  logic [3:0]  SEL;
  logic [2:0]  CTI;
  logic [1:0]  BTE;
  logic        ACK;
  logic        ERR;
  logic [3:0]  wait_cycles;

  int checks = 0;
  int errors = 0;

  wb_slave_sram #(
    .WB_ADDR_WIDTH(32),
    .WB_DATA_WIDTH(32),
    .MEM_WORDS(1024)
  ) dut (
    .clk(clk), .rstn(rstn), .ADR(ADR), .DAT_W(DAT_W), .DAT_R(DAT_R),
    .CYC(CYC), .STB(STB), .WE(WE), .SEL(SEL), .CTI(CTI), .BTE(BTE),
    .ACK(ACK), .ERR(ERR), .wait_cycles(wait_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Classic cycle driven at negedges; returns data, response flags, latency in cycles and
  // whether ACK/ERR was still high one cycle later with the request held.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd, output logic ack,
                         output logic err, output logic after, output int lat);
    @(negedge clk);
    CYC = 1'b1; STB = 1'b1; WE = we; ADR = adr; DAT_W = dat; SEL = sel;
    CTI = 3'b000; BTE = 2'b00;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ACK && !ERR && lat < 40);
    rd  = DAT_R;
    ack = ACK;
    err = ERR;
    @(negedge clk);
    after = ACK | ERR;
    CYC = 1'b0; STB = 1'b0; WE = 1'b0;
  endtask

  logic [31:0] rd;
  logic        ack, err, after;
  int          lat;
  logic [31:0] exp_wrap [4];

  initial begin
    rstn = 1'b0; CYC = 1'b0; STB = 1'b0; WE = 1'b0; ADR = '0; DAT_W = '0;
    SEL = '0; CTI = '0; BTE = '0; wait_cycles = 4'd0;
    exp_wrap[0] = 32'd3; exp_wrap[1] = 32'd4; exp_wrap[2] = 32'd1; exp_wrap[3] = 32'd2;

    repeat (2) @(negedge clk);
    chk("rst_ack", {31'd0, ACK}, 32'd0);
    chk("rst_err", {31'd0, ERR}, 32'd0);
    chk("rst_dat", DAT_R, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    wb_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, ack, err, after, lat);
    chk("wr10_ack", {31'd0, ack}, 32'd1);
    chk("wr10_err", {31'd0, err}, 32'd0);
    chk("wr10_lat", lat, 32'd1);
    chk("wr10_1cyc", {31'd0, after}, 32'd0);

    wb_xfer(1'b0, 32'h10, 32'h0, 4'hF, rd, ack, err, after, lat);
    chk("rd10_dat", rd, 32'hDEADBEEF);
    chk("rd10_lat", lat, 32'd1);

    wb_xfer(1'b1, 32'h20, 32'h11223344, 4'hF, rd, ack, err, after, lat);
    wb_xfer(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, ack, err, after, lat);
    chk("sel_ack", {31'd0, ack}, 32'd1);
    wb_xfer(1'b0, 32'h20, 32'h0, 4'hF, rd, ack, err, after, lat);
    chk("sel_dat", rd, 32'h11BB33DD);

    wait_cycles = 4'd3;
    wb_xfer(1'b0, 32'h10, 32'h0, 4'hF, rd, ack, err, after, lat);
    chk("ws3_lat", lat, 32'd4);
    chk("ws3_dat", rd, 32'hDEADBEEF);
    chk("ws3_1cyc", {31'd0, after}, 32'd0);
    wait_cycles = 4'd0;

    for (int i = 0; i < 4; i++)
      wb_xfer(1'b1, 32'h40 + 32'(4*i), 32'(i + 1), 4'hF, rd, ack, err, after, lat);
    wb_xfer(1'b1, 32'h0, 32'hCAFE0000, 4'hF, rd, ack, err, after, lat);

    // Wrap-4 read from 0x48: the bus shows the next beat's CTI while the current ACK is high.
    @(negedge clk);
    CYC = 1'b1; STB = 1'b1; WE = 1'b0; ADR = 32'h48; CTI = 3'b010; BTE = 2'b01;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("wrap_ack%0d", k), {31'd0, ACK}, 32'd1);
      chk($sformatf("wrap_dat%0d", k), DAT_R, exp_wrap[k]);
      if (k == 2) CTI = 3'b111;
      if (k == 3) begin CYC = 1'b0; STB = 1'b0; CTI = 3'b000; end
    end
    @(negedge clk);
    chk("wrap_end", {31'd0, ACK}, 32'd0);

    // Linear read from 0x40 with a master-inserted hold after the first beat.
    @(negedge clk);
    CYC = 1'b1; STB = 1'b1; WE = 1'b0; ADR = 32'h40; CTI = 3'b010; BTE = 2'b00;
    @(negedge clk);
    chk("lin_dat0", DAT_R, 32'd1);
    STB = 1'b0;
    @(negedge clk);
    chk("lin_hold", {31'd0, ACK}, 32'd0);
    STB = 1'b1;
    @(negedge clk);
    chk("lin_dat1", DAT_R, 32'd2);
    CTI = 3'b111;
    @(negedge clk);
    chk("lin_dat2", DAT_R, 32'd3);
    CYC = 1'b0; STB = 1'b0; CTI = 3'b000;
    @(negedge clk);
    chk("lin_end", {31'd0, ACK}, 32'd0);

    wb_xfer(1'b1, 32'h1000, 32'h12345678, 4'hF, rd, ack, err, after, lat);
    chk("oor_err", {31'd0, err}, 32'd1);
    chk("oor_ack", {31'd0, ack}, 32'd0);
    chk("oor_1cyc", {31'd0, after}, 32'd0);
    wb_xfer(1'b0, 32'h0, 32'h0, 4'hF, rd, ack, err, after, lat);
    chk("oor_word0", rd, 32'hCAFE0000);

    // Linear write burst to 0x40; reset lands while beat 2 is presented, before its ACK edge.
    @(negedge clk);
    CYC = 1'b1; STB = 1'b1; WE = 1'b1; ADR = 32'h40; SEL = 4'hF; DAT_W = 32'hA0;
    CTI = 3'b010; BTE = 2'b00;
    @(negedge clk);
    DAT_W = 32'hA1;
    @(negedge clk);
    chk("rstb_ack1", {31'd0, ACK}, 32'd1);
    DAT_W = 32'hA2;
    rstn = 1'b0;
    #1;
    chk("rstb_ack", {31'd0, ACK}, 32'd0);
    chk("rstb_err", {31'd0, ERR}, 32'd0);
    repeat (2) @(negedge clk);
    CYC = 1'b0; STB = 1'b0; WE = 1'b0; CTI = 3'b000;
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      wb_xfer(1'b0, 32'h40 + 32'(4*i), 32'h0, 4'hF, rd, ack, err, after, lat);
      chk($sformatf("rstb_word%0d", i), rd, (i == 0) ? 32'hA0 : (i == 1) ? 32'hA1 : 32'(i + 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
